// File: rtl/reg_ctrl_pkg.sv
// Shared definitions for the register control sequencer: opcode values,
// FSM state encoding and small opcode classification helpers.
package reg_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_CLR  = 4'd1;
    localparam logic [3:0] OP_LOAD = 4'd2;
    localparam logic [3:0] OP_INC  = 4'd3;
    localparam logic [3:0] OP_DEC  = 4'd4;
    localparam logic [3:0] OP_SHR  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_ROR  = 4'd7;
    localparam logic [3:0] OP_ROL  = 4'd8;
    localparam logic [3:0] OP_ASR  = 4'd9;

    // Opcodes 10..15 are reserved and rejected with an error pulse.
    function automatic logic op_is_legal(input logic [3:0] op);
        return (op <= OP_ASR);
    endfunction

    // Opcodes whose RUN length is taken from the repeat count.
    function automatic logic op_is_repeat(input logic [3:0] op);
        return ((op >= OP_INC) && (op <= OP_ASR));
    endfunction

endpackage

// File: rtl/reg_ctrl_seq.sv
// Command sequencer driving the control strobes of an external shift/count
// register. A command is accepted in IDLE, its strobe is issued for the
// required number of RUN cycles, and FIN reports completion for one cycle.
module reg_ctrl_seq
    import reg_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [3:0]            cmd_op,
    input  logic [CNT_WIDTH-1:0]  cmd_cnt,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic                  cmd_fill,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] reg_q,
    output logic                  cl,
    output logic                  ld,
    output logic                  inc,
    output logic                  dec,
    output logic                  sr,
    output logic                  sl,
    output logic                  ir,
    output logic                  il,
    output logic [DATA_WIDTH-1:0] din,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    state_e                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [3:0]              op_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    fill_q;
    logic                    err_q;
    logic                    accept_s;
    logic                    reg_mid_unused_s;

    assign accept_s = cmd_valid && (state_q == ST_IDLE);

    // Only the end bits of the register feed the serial inputs.
    assign reg_mid_unused_s = ^reg_q;

    // State and remaining-count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Command latch and illegal-opcode pulse register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= OP_NOP;
            data_q <= '0;
            fill_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            err_q <= accept_s && !op_is_legal(cmd_op);
            if (accept_s) begin
                op_q   <= cmd_op;
                data_q <= cmd_data;
                fill_q <= cmd_fill;
            end else begin
                op_q   <= op_q;
                data_q <= data_q;
                fill_q <= fill_q;
            end
        end
    end

    // Next state and counter: CLR/LOAD run once, repeat ops run cnt times,
    // NOP or a zero count goes straight to FIN; abort returns to IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (!accept_s) begin
                    state_d = ST_IDLE;
                end else if (!op_is_legal(cmd_op)) begin
                    state_d = ST_IDLE;
                end else if ((cmd_op == OP_CLR) || (cmd_op == OP_LOAD)) begin
                    state_d = ST_RUN;
                    cnt_d   = CNT_WIDTH'(1);
                end else if (op_is_repeat(cmd_op) && (cmd_cnt != '0)) begin
                    state_d = ST_RUN;
                    cnt_d   = cmd_cnt;
                end else begin
                    state_d = ST_FIN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q <= CNT_WIDTH'(1)) begin
                    state_d = ST_FIN;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_RUN;
                    cnt_d   = cnt_q - CNT_WIDTH'(1);
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Strobe and serial-bit decode from the latched opcode, active only in RUN.
    always_comb begin
        cl  = 1'b0;
        ld  = 1'b0;
        inc = 1'b0;
        dec = 1'b0;
        sr  = 1'b0;
        sl  = 1'b0;
        ir  = 1'b0;
        il  = 1'b0;
        if (state_q == ST_RUN) begin
            case (op_q)
                OP_CLR:  cl = 1'b1;
                OP_LOAD: ld = 1'b1;
                OP_INC:  inc = 1'b1;
                OP_DEC:  dec = 1'b1;
                OP_SHR:  begin sr = 1'b1; ir = fill_q;               end
                OP_ROR:  begin sr = 1'b1; ir = reg_q[0];             end
                OP_ASR:  begin sr = 1'b1; ir = reg_q[DATA_WIDTH-1];  end
                OP_SHL:  begin sl = 1'b1; il = fill_q;               end
                OP_ROL:  begin sl = 1'b1; il = reg_q[DATA_WIDTH-1];  end
                default: begin sr = 1'b0; sl = 1'b0;                 end
            endcase
        end else begin
            ir = 1'b0;
            il = 1'b0;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_RUN) || (state_q == ST_FIN);
    assign done      = (state_q == ST_FIN);
    assign err       = err_q;
    assign din       = data_q;

endmodule

// File: tb/tb_reg_ctrl_seq.sv
// Bench for reg_ctrl_seq: couples the sequencer to a 16-bit register and
// compares each cycle against a value model of the command semantics.
module tb_reg_ctrl_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = 4'd0;
    logic [3:0]  cmd_cnt = 4'd0;
    logic [15:0] cmd_data = 16'h0;
    logic        cmd_fill = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] reg_q;
    logic        cl, ld, inc, dec, sr, sl, ir, il;
    logic [15:0] din;
    logic        busy, done, err;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [15:0] mdl_q    = 16'h0;

    always #5 clk = ~clk;

    reg_ctrl_seq #(.DATA_WIDTH(16), .CNT_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .cmd_data(cmd_data), .cmd_fill(cmd_fill),
        .abort(abort), .reg_q(reg_q), .cl(cl), .ld(ld), .inc(inc), .dec(dec),
        .sr(sr), .sl(sl), .ir(ir), .il(il), .din(din), .busy(busy), .done(done),
        .err(err)
    );

    // The controlled 16-bit register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   reg_q <= 16'h0;
        else if (cl)  reg_q <= 16'h0;
        else if (ld)  reg_q <= din;
        else if (inc) reg_q <= reg_q + 16'd1;
        else if (dec) reg_q <= reg_q - 16'd1;
        else if (sr)  reg_q <= {ir, reg_q[15:1]};
        else if (sl)  reg_q <= {reg_q[14:0], il};
        else          reg_q <= reg_q;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One-hot {cl,ld,inc,dec,sr,sl} expected while an opcode is running.
    function automatic logic [5:0] exp_strobe(input logic [3:0] op);
        case (op)
            4'd1:             return 6'b100000;
            4'd2:             return 6'b010000;
            4'd3:             return 6'b001000;
            4'd4:             return 6'b000100;
            4'd5, 4'd7, 4'd9: return 6'b000010;
            4'd6, 4'd8:       return 6'b000001;
            default:          return 6'b000000;
        endcase
    endfunction

    function automatic int run_len(input logic [3:0] op, input logic [3:0] cnt);
        if (op == 4'd1 || op == 4'd2) return 1;
        if (op >= 4'd3 && op <= 4'd9) return int'(cnt);
        return 0;
    endfunction

    // Register value after one application of the operation.
    function automatic logic [15:0] step(input logic [3:0] op, input logic [15:0] v,
                                         input logic [15:0] d, input logic f);
        int u;
        int fb;
        u  = int'(v);
        fb = f ? 1 : 0;
        case (op)
            4'd1: u = 0;
            4'd2: u = int'(d);
            4'd3: u = (u + 1) % 65536;
            4'd4: u = (u + 65535) % 65536;
            4'd5: u = (u / 2) + fb * 32768;
            4'd6: u = ((u * 2) % 65536) + fb;
            4'd7: u = (u / 2) + (u % 2) * 32768;
            4'd8: u = ((u * 2) % 65536) + (u / 32768);
            4'd9: u = (u / 2) + (u / 32768) * 32768;
            default: u = u;
        endcase
        return u[15:0];
    endfunction

    function automatic logic [1:0] exp_serial(input logic [3:0] op, input logic [15:0] v,
                                              input logic f);
        case (op)
            4'd5:    return {f, 1'b0};
            4'd7:    return {v[0], 1'b0};
            4'd9:    return {v[15], 1'b0};
            4'd6:    return {1'b0, f};
            4'd8:    return {1'b0, v[15]};
            default: return 2'b00;
        endcase
    endfunction

    task automatic run_cmd(input logic [3:0] op, input logic [3:0] cnt,
                           input logic [15:0] data, input logic fill, input int abort_at);
        int len;
        bit aborted;
        len     = run_len(op, cnt);
        aborted = 1'b0;
        check("ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_cnt = cnt; cmd_data = data; cmd_fill = fill;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = 4'($urandom_range(0, 15)); cmd_data = 16'($urandom);
        check("din_latched", din, data);
        if (op > 4'd9) begin
            check("err_pulse", err, 1);
            check("err_no_strobe", {cl, ld, inc, dec, sr, sl}, 0);
            check("err_ready", cmd_ready, 1);
            check("err_no_done", done, 0);
            @(posedge clk); #1;
            check("err_one_cycle", err, 0);
            check("err_no_done_later", done, 0);
            check("err_reg_kept", reg_q, mdl_q);
            return;
        end
        for (int c = 0; c < len; c++) begin
            if (c == abort_at) abort = 1'b1;
            check("run_strobe", {cl, ld, inc, dec, sr, sl}, exp_strobe(op));
            check("run_serial", {ir, il}, exp_serial(op, mdl_q, fill));
            check("run_reg", reg_q, mdl_q);
            check("run_busy_nodone", {busy, done, cmd_ready}, 3'b100);
            @(posedge clk); #1;
            abort = 1'b0;
            mdl_q = step(op, mdl_q, data, fill);
            if (c == abort_at) begin
                aborted = 1'b1;
                break;
            end
        end
        if (aborted) begin
            check("abort_idle", {busy, done, cmd_ready}, 3'b001);
            check("abort_no_strobe", {cl, ld, inc, dec, sr, sl}, 0);
        end else begin
            check("fin_done", {busy, done, cmd_ready}, 3'b110);
            check("fin_no_strobe", {cl, ld, inc, dec, sr, sl, ir, il}, 0);
            @(posedge clk); #1;
            check("post_fin_idle", {busy, done, cmd_ready}, 3'b001);
        end
        check("final_reg", reg_q, mdl_q);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {cmd_ready, busy, done, err, cl, ld, inc, dec, sr, sl, ir, il},
              12'b1000_0000_0000);
        check("reset_din", din, 16'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_after_reset", {cmd_ready, busy, done}, 3'b100);

        // LOAD then INC x5.
        run_cmd(4'd2, 4'd0, 16'h1234, 1'b0, -1);
        run_cmd(4'd3, 4'd5, 16'h0, 1'b0, -1);
        check("load_inc5", reg_q, 16'h1239);

        // Rotate / arithmetic shift / fill shift.
        run_cmd(4'd2, 4'd0, 16'h8001, 1'b0, -1);
        run_cmd(4'd7, 4'd1, 16'h0, 1'b0, -1);
        check("ror1", reg_q, 16'hC000);
        run_cmd(4'd2, 4'd0, 16'h8000, 1'b0, -1);
        run_cmd(4'd9, 4'd3, 16'h0, 1'b0, -1);
        check("asr3", reg_q, 16'hF000);
        run_cmd(4'd1, 4'd0, 16'h0, 1'b0, -1);
        run_cmd(4'd6, 4'd4, 16'h0, 1'b1, -1);
        check("shl_fill4", reg_q, 16'h000F);

        // Zero count, illegal opcode.
        run_cmd(4'd1, 4'd0, 16'h0, 1'b0, -1);
        run_cmd(4'd4, 4'd0, 16'h0, 1'b0, -1);
        check("dec_cnt0", reg_q, 16'h0000);
        run_cmd(4'd12, 4'd3, 16'h5555, 1'b0, -1);
        check("illegal_reg", reg_q, 16'h0000);

        // Abort on the 4th RUN cycle of INC x15.
        run_cmd(4'd3, 4'd15, 16'h0, 1'b0, 3);
        check("abort_inc", reg_q, 16'h0004);

        // Random commands with occasional abort.
        for (int k = 0; k < 40; k++) begin
            logic [3:0] op;
            int         ab;
            op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15))
                                             : 4'($urandom_range(0, 9));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
            run_cmd(op, 4'($urandom_range(0, 15)), 16'($urandom), 1'($urandom), ab);
        end

        // Reset in the middle of SHR x8.
        run_cmd(4'd2, 4'd0, 16'hA5A5, 1'b0, -1);
        cmd_valid = 1'b1; cmd_op = 4'd5; cmd_cnt = 4'd8; cmd_fill = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pre_reset_running", {sr, busy}, 2'b11);
        #3 rst_n = 1'b0;
        #1;
        check("reset_mid_run", {cl, ld, inc, dec, sr, sl, ir, il, busy, done, cmd_ready},
              11'b000_0000_0001);
        check("reset_mid_run_reg", reg_q, 16'h0);
        mdl_q = 16'h0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            check("no_done_after_reset", {done, busy, cmd_ready}, 3'b001);
            @(posedge clk); #1;
        end
        run_cmd(4'd3, 4'd2, 16'h0, 1'b0, -1);
        check("after_reset_inc2", reg_q, 16'h0002);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
